// File: rtl/lsu_ctrl.sv
// lsu_ctrl: RV32 load/store unit controller. Accepts one request at a time,
// steers store lanes / byte enables onto a single word-wide memory port,
// optionally splits misaligned accesses into two word beats, and returns
// an extended load result with a one-cycle completion pulse.
module lsu_ctrl #(
    parameter int READ_LATENCY   = 1,
    parameter bit MISALIGN_SPLIT = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        mem_en,
    output logic [3:0]  mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_misaligned,
    output logic        resp_illegal
);

    typedef enum logic [2:0] {
        IDLE, BEAT0, WAIT0, BEAT1, WAIT1, RESP
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [31:0] rd_lo_q, rd_lo_d;
    logic [31:0] rd_hi_q, rd_hi_d;

    // captured request
    logic        we_q;
    logic [2:0]  f3_q;
    logic [1:0]  off_q;
    logic [29:0] base_q;
    logic [63:0] wlanes_q;
    logic [7:0]  wmask_q;
    logic        split_q;
    logic        ill_q;
    logic        mis_q;
    logic        err_q;

    // request decode, evaluated on the incoming fields
    logic       acc;
    logic       ill_c;
    logic       mis_c;
    logic       err_c;
    logic [3:0] size_m;

    assign acc   = req_valid & req_ready;
    assign ill_c = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11) ||
                   (req_we && req_funct3[2]);
    // only legal codes reach here, so funct3[1:0] is the size
    assign mis_c = !ill_c &&
                   ((req_funct3[1:0] == 2'b01 && req_addr[1:0] == 2'b11) ||
                    (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00));
    assign err_c = ill_c || (mis_c && !MISALIGN_SPLIT);

    // size mask per funct3 width
    always_comb begin
        case (req_funct3[1:0])
            2'b00:   size_m = 4'b0001;
            2'b01:   size_m = 4'b0011;
            default: size_m = 4'b1111;
        endcase
    end

    // load result: {beat1, beat0} shifted down by the byte offset, then extended
    logic [31:0] ld_word;
    logic [31:0] ld_ext;
    assign ld_word = 32'({rd_hi_q, rd_lo_q} >> {off_q, 3'b000});

    always_comb begin
        case (f3_q)
            3'b000:  ld_ext = {{24{ld_word[7]}}, ld_word[7:0]};
            3'b001:  ld_ext = {{16{ld_word[15]}}, ld_word[15:0]};
            3'b100:  ld_ext = {24'b0, ld_word[7:0]};
            3'b101:  ld_ext = {16'b0, ld_word[15:0]};
            default: ld_ext = ld_word;
        endcase
    end

    // state, wait counter and read-data capture registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rd_lo_q <= '0;
            rd_hi_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rd_lo_q <= rd_lo_d;
            rd_hi_q <= rd_hi_d;
        end
    end

    // request capture at acceptance; lanes and enables are pre-steered here
    always_ff @(posedge clk) begin
        if (rst) begin
            we_q     <= 1'b0;
            f3_q     <= '0;
            off_q    <= '0;
            base_q   <= '0;
            wlanes_q <= '0;
            wmask_q  <= '0;
            split_q  <= 1'b0;
            ill_q    <= 1'b0;
            mis_q    <= 1'b0;
            err_q    <= 1'b0;
        end else if (acc) begin
            we_q     <= req_we;
            f3_q     <= req_funct3;
            off_q    <= req_addr[1:0];
            base_q   <= req_addr[31:2];
            wlanes_q <= {32'b0, req_wdata} << {req_addr[1:0], 3'b000};
            wmask_q  <= 8'({4'b0, size_m} << req_addr[1:0]);
            split_q  <= mis_c && MISALIGN_SPLIT;
            ill_q    <= ill_c;
            mis_q    <= mis_c;
            err_q    <= err_c;
        end
    end

    // next-state and outputs; memory fields stay 0 outside beat cycles
    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        rd_lo_d         = rd_lo_q;
        rd_hi_d         = rd_hi_q;
        req_ready       = 1'b0;
        mem_en          = 1'b0;
        mem_we          = '0;
        mem_addr        = '0;
        mem_wdata       = '0;
        resp_valid      = 1'b0;
        resp_rdata      = '0;
        resp_misaligned = 1'b0;
        resp_illegal    = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_d = err_c ? RESP : BEAT0;
            end
            BEAT0: begin
                mem_en   = 1'b1;
                mem_addr = {base_q, 2'b00};
                if (we_q) begin
                    mem_we    = wmask_q[3:0];
                    mem_wdata = wlanes_q[31:0];
                    state_d   = split_q ? BEAT1 : RESP;
                end else begin
                    cnt_d   = 3'd1;
                    state_d = WAIT0;
                end
            end
            WAIT0: begin
                if (cnt_q == 3'(READ_LATENCY)) begin
                    rd_lo_d = mem_rdata;
                    state_d = split_q ? BEAT1 : RESP;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            BEAT1: begin
                mem_en   = 1'b1;
                mem_addr = {base_q + 30'd1, 2'b00};
                if (we_q) begin
                    mem_we    = wmask_q[7:4];
                    mem_wdata = wlanes_q[63:32];
                    state_d   = RESP;
                end else begin
                    cnt_d   = 3'd1;
                    state_d = WAIT1;
                end
            end
            WAIT1: begin
                if (cnt_q == 3'(READ_LATENCY)) begin
                    rd_hi_d = mem_rdata;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            RESP: begin
                resp_valid      = 1'b1;
                resp_illegal    = ill_q;
                resp_misaligned = mis_q && !ill_q && !MISALIGN_SPLIT;
                if (!we_q && !err_q) resp_rdata = ld_ext;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // reset cycles present a quiet, not-ready interface
        if (rst) begin
            req_ready       = 1'b0;
            mem_en          = 1'b0;
            mem_we          = '0;
            mem_addr        = '0;
            mem_wdata       = '0;
            resp_valid      = 1'b0;
            resp_rdata      = '0;
            resp_misaligned = 1'b0;
            resp_illegal    = 1'b0;
        end
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: random + directed stimulus against a transaction-level model
// that predicts, per cycle, every output of the split-enabled instance.
// A second instance with splitting disabled covers the reject path.
module tb_lsu_ctrl;

    localparam int RL = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic        req_valid = 0, req_we = 0;
    logic [2:0]  req_funct3 = 0;
    logic [31:0] req_addr = 0, req_wdata = 0, mem_rdata = 0;
    logic        req_ready, mem_en, resp_valid, resp_misaligned, resp_illegal;
    logic [3:0]  mem_we;
    logic [31:0] mem_addr, mem_wdata, resp_rdata;

    logic        n_req_valid = 0, n_req_we = 0;
    logic [2:0]  n_req_funct3 = 0;
    logic [31:0] n_req_addr = 0, n_req_wdata = 0, n_mem_rdata = 0;
    logic        n_req_ready, n_mem_en, n_resp_valid, n_resp_misaligned, n_resp_illegal;
    logic [3:0]  n_mem_we;
    logic [31:0] n_mem_addr, n_mem_wdata, n_resp_rdata;

    lsu_ctrl #(.READ_LATENCY(RL), .MISALIGN_SPLIT(1'b1)) u_dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr),
        .req_wdata(req_wdata), .mem_en(mem_en), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_misaligned(resp_misaligned), .resp_illegal(resp_illegal)
    );

    lsu_ctrl #(.READ_LATENCY(RL), .MISALIGN_SPLIT(1'b0)) u_ns (
        .clk(clk), .rst(rst), .req_valid(n_req_valid), .req_ready(n_req_ready),
        .req_we(n_req_we), .req_funct3(n_req_funct3), .req_addr(n_req_addr),
        .req_wdata(n_req_wdata), .mem_en(n_mem_en), .mem_we(n_mem_we),
        .mem_addr(n_mem_addr), .mem_wdata(n_mem_wdata), .mem_rdata(n_mem_rdata),
        .resp_valid(n_resp_valid), .resp_rdata(n_resp_rdata),
        .resp_misaligned(n_resp_misaligned), .resp_illegal(n_resp_illegal)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // per-cycle expectations; an absent key means the output is 0
    bit          e_en[int], e_rv[int], e_mis[int], e_ill[int], e_busy[int], e_rst[int];
    logic [3:0]  e_we[int];
    logic [31:0] e_addr[int], e_wd[int], e_rd[int];
    logic [31:0] mem_pre[logic [31:0]];
    logic [31:0] rd_sched[int];

    // read-only memory contents: a few pinned words, hash elsewhere
    function automatic logic [31:0] memf(input logic [31:0] a);
        if (mem_pre.exists(a)) return mem_pre[a];
        return (a * 32'h9E3779B1) ^ 32'h5A5A1234;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
        end
    endtask

    // reference model: fills expectations for a request accepted at cycle t
    task automatic model(input bit we, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input int t, output int r);
        bit          ill, mis;
        int          nb, off, beats, c;
        logic [31:0] base, msk, res;
        logic [63:0] lanes, dat;
        logic [7:0]  m8;
        ill = (f3 == 3) || (f3 >= 6) || (we && f3 >= 4);
        nb  = (f3[1:0] == 0) ? 1 : (f3[1:0] == 1) ? 2 : 4;
        off = int'(a[1:0]);
        mis = !ill && (off + nb > 4);
        base = a & ~32'd3;
        beats = mis ? 2 : 1;
        if (ill) begin
            r = t + 1;
            e_ill[r] = 1;
        end else if (we) begin
            lanes = {32'b0, wd} << (8 * off);
            m8 = 8'(((1 << nb) - 1) << off);
            for (int b = 0; b < beats; b++) begin
                c = t + 1 + b;
                e_en[c]   = 1;
                e_addr[c] = base + 32'(4 * b);
                e_we[c]   = 4'(m8 >> (4 * b));
                e_wd[c]   = 32'(lanes >> (32 * b));
            end
            r = t + 1 + beats;
        end else begin
            for (int b = 0; b < beats; b++) begin
                c = t + 1 + b * (RL + 1);
                e_en[c]   = 1;
                e_addr[c] = base + 32'(4 * b);
            end
            r = t + 1 + beats * (RL + 1);
            dat = {memf(base + 32'd4), memf(base)} >> (8 * off);
            msk = (nb == 4) ? 32'hFFFFFFFF : 32'((64'd1 << (8 * nb)) - 1);
            res = dat[31:0] & msk;
            if (!f3[2] && nb < 4 && res[8 * nb - 1]) res = res | ~msk;
            e_rd[r] = res;
        end
        e_rv[r] = 1;
        for (int k = t + 1; k <= r; k++) e_busy[k] = 1;
    endtask

    // single compare process for the main instance
    always @(negedge clk) begin
        if (cyc >= 1) begin
            bit rs;
            rs = e_rst.exists(cyc);
            check("req_ready", 32'(req_ready), (rs || e_busy.exists(cyc)) ? 32'd0 : 32'd1);
            check("mem_en",    32'(mem_en),    32'(!rs && e_en.exists(cyc)));
            check("mem_we",    32'(mem_we),    (!rs && e_we.exists(cyc)) ? 32'(e_we[cyc]) : 32'd0);
            check("mem_addr",  mem_addr,       (!rs && e_addr.exists(cyc)) ? e_addr[cyc] : 32'd0);
            check("mem_wdata", mem_wdata,      (!rs && e_wd.exists(cyc)) ? e_wd[cyc] : 32'd0);
            check("resp_valid", 32'(resp_valid), 32'(!rs && e_rv.exists(cyc)));
            check("resp_rdata", resp_rdata,    (!rs && e_rd.exists(cyc)) ? e_rd[cyc] : 32'd0);
            check("resp_mis",  32'(resp_misaligned), 32'(!rs && e_mis.exists(cyc)));
            check("resp_ill",  32'(resp_illegal),    32'(!rs && e_ill.exists(cyc)));
            if (mem_en && mem_we == 4'd0) rd_sched[cyc + RL] = mem_addr;
        end
    end

    // memory responder: real data only in the cycle it is due, noise otherwise
    always @(posedge clk) begin
        #1;
        mem_rdata = rd_sched.exists(cyc) ? memf(rd_sched[cyc]) : $urandom;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // drive one request (DUT idle), garbage inputs while busy, return at r+1
    task automatic issue(input bit we, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, output int t, output int r);
        req_valid = 1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
        t = cyc;
        model(we, f3, a, wd, t, r);
        step();
        while (cyc <= r) begin
            req_valid = 1'($urandom); req_we = 1'($urandom); req_funct3 = 3'($urandom);
            req_addr = $urandom; req_wdata = $urandom;
            step();
        end
        req_valid = 0;
    endtask

    // reject-path request on the non-split instance
    task automatic n_err(input bit we, input logic [2:0] f3, input logic [31:0] a,
                         input bit x_mis, input bit x_ill);
        n_req_valid = 1; n_req_we = we; n_req_funct3 = f3; n_req_addr = a;
        n_req_wdata = $urandom;
        step();
        n_req_valid = 0;
        @(negedge clk);
        check("n_resp_valid", 32'(n_resp_valid), 32'd1);
        check("n_resp_mis",   32'(n_resp_misaligned), 32'(x_mis));
        check("n_resp_ill",   32'(n_resp_illegal), 32'(x_ill));
        check("n_mem_en",     32'(n_mem_en), 32'd0);
        check("n_ready_resp", 32'(n_req_ready), 32'd0);
        step();
        check("n_ready_next", 32'(n_req_ready), 32'd1);
    endtask

    initial begin
        int t, r;
        logic [31:0] a;
        e_rst[1] = 1; e_rst[2] = 1;
        mem_pre[32'h2000] = 32'h80011234;
        mem_pre[32'h4000] = 32'h11223344;
        mem_pre[32'h4004] = 32'h55667788;
        while (cyc < 3) step();
        rst = 0;
        @(negedge clk);
        check("ready_after_rst", 32'(req_ready), 32'd1);
        step();

        // pinned cases: the model must reproduce these hand values
        issue(1, 3'b000, 32'h1002, 32'h000000AB, t, r);
        check("sb_we",    32'(e_we[t + 1]), 32'h4);
        check("sb_addr",  e_addr[t + 1], 32'h1000);
        check("sb_wdata", e_wd[t + 1], 32'h00AB0000);
        check("sb_lat",   32'(r - t), 32'd2);
        issue(0, 3'b001, 32'h2002, 32'h0, t, r);
        check("lh_lat",   32'(r - t), 32'd4);
        check("lh_data",  e_rd[r], 32'hFFFF8001);
        issue(0, 3'b101, 32'h2002, 32'h0, t, r);
        check("lhu_data", e_rd[r], 32'h00008001);
        issue(1, 3'b010, 32'h3001, 32'hDDCCBBAA, t, r);
        check("sw_b0",    {e_addr[t + 1][27:0], e_we[t + 1]}, {28'h0003000, 4'b1110});
        check("sw_b0_wd", e_wd[t + 1], 32'hCCBBAA00);
        check("sw_b1",    {e_addr[t + 2][27:0], e_we[t + 2]}, {28'h0003004, 4'b0001});
        check("sw_b1_wd", e_wd[t + 2], 32'h000000DD);
        check("sw_lat",   32'(r - t), 32'd3);
        issue(0, 3'b010, 32'h4003, 32'h0, t, r);
        check("lw_lat",   32'(r - t), 32'd7);
        check("lw_data",  e_rd[r], 32'h66778811);
        issue(0, 3'b010, 32'hFFFFFFFD, 32'h0, t, r);
        check("wrap_b1",  e_addr[t + 2 + RL], 32'h0);
        issue(1, 3'b001, 32'hFFFFFFFF, 32'h0000BEEF, t, r);
        issue(0, 3'b011, 32'h0000000C, 32'h0, t, r);

        // reset during WAIT0 of a load abandons it
        req_valid = 1; req_we = 0; req_funct3 = 3'b010; req_addr = 32'h6000;
        t = cyc;
        model(0, 3'b010, 32'h6000, 32'h0, t, r);
        step();
        req_valid = 0;
        step();
        rst = 1;
        e_rst[cyc] = 1;
        for (int c = cyc; c <= r; c++) begin
            e_en.delete(c); e_we.delete(c); e_addr.delete(c); e_wd.delete(c);
            e_rv.delete(c); e_rd.delete(c); e_busy.delete(c);
        end
        step();
        rst = 0;
        @(negedge clk);
        check("rst_mid_ready", 32'(req_ready), 32'd1);
        step();
        repeat (8) step();

        // randomized traffic
        for (int i = 0; i < 300; i++) begin
            repeat ($urandom_range(0, 2)) begin
                req_funct3 = 3'($urandom); req_addr = $urandom;
                step();
            end
            a = ($urandom_range(0, 7) == 0) ? {30'h3FFFFFFF, 2'($urandom)} : $urandom;
            issue(1'($urandom), 3'($urandom), a, $urandom, t, r);
        end

        // non-split instance: rejects and illegal priority
        n_err(0, 3'b010, 32'h5002, 1, 0);
        n_err(0, 3'b011, 32'h5000, 0, 1);
        n_err(1, 3'b101, 32'h5003, 0, 1);
        n_err(0, 3'b001, 32'h5003, 1, 0);
        n_req_valid = 1; n_req_we = 1; n_req_funct3 = 3'b010; n_req_addr = 32'h5004;
        n_req_wdata = 32'h12345678;
        step();
        n_req_valid = 0;
        @(negedge clk);
        check("n_sw_en",   32'(n_mem_en), 32'd1);
        check("n_sw_we",   32'(n_mem_we), 32'hF);
        check("n_sw_wd",   n_mem_wdata, 32'h12345678);
        step();
        check("n_sw_resp", 32'(n_resp_valid), 32'd1);
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog cyc=%0d", cyc);
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

endmodule
